// File: rtl/dmem_controller.sv
// Handshaked, byte-addressable data memory for the RV32I load/store path.
// It has configurable depth and wait states, fault reporting and a post-reset clear sweep.
module dmem_controller #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned FULL_W = ADDR_W - 2;

  typedef enum logic [1:0] {StClear, StIdle, StAccess} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic [3:0]        wait_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [FULL_W-1:0] word_full;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              fault;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data;
  logic [31:0]       merged;
  logic              do_access;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  assign word_full    = addr_q[ADDR_W-1:2];
  assign word_idx     = word_full[IDX_W-1:0];
  assign lane         = addr_q[1:0];
  // Any set bit above the index field means the word lies past the end of the array.
  assign out_of_range = (word_full >> IDX_W) != '0;
  assign rd_word      = mem[word_idx];
  assign shifted      = rd_word >> {lane, 3'b000};

  always_comb begin
    fault = 1'b0;
    case (funct3_q)
      3'b000:  fault = 1'b0;
      3'b001:  fault = lane[0];
      3'b010:  fault = (lane != 2'b00);
      3'b100:  fault = we_q;
      3'b101:  fault = we_q | lane[0];
      default: fault = 1'b1;
    endcase
    if (out_of_range) begin
      fault = 1'b1;
    end
  end

  // funct3[2] selects zero extension for the unsigned byte/halfword loads.
  always_comb begin
    load_data = '0;
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    byte_en   = 4'b0000;
    lane_data = '0;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

  assign do_access = (state_q == StAccess) && (wait_q == 4'd0);
  // Gating with rst makes a reset edge abort both clear writes and pending stores.
  assign mem_we    = rst && ((state_q == StClear) || (do_access && we_q && !fault));
  assign mem_idx   = (state_q == StClear) ? clr_cnt_q : word_idx;
  assign mem_wdata = (state_q == StClear) ? 32'h0 : merged;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_cnt_q <= '0;
      wait_q    <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      init_done <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        StIdle: begin
          init_done <= 1'b1;
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wait_q    <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            state_q   <= StAccess;
          end else begin
            req_ready <= 1'b1;
          end
        end
        StAccess: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_rdata <= (fault || we_q) ? 32'h0 : load_data;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Parametrised, handshaked data memory for the RV32I core's load/store path. It replaces the combinational-read, fixed-depth data memory. It adds configurable depth and wait states, a valid/ready request channel and a registered response. It also adds misalignment and range fault reporting, and a hardware clear sequence after reset. It sits between the core's memory stage and the word-organised, byte-addressable data store.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words, power of two, 4..4096.
- ADDR_W, 32: request byte-address width.
- WAIT_STATES, 0: extra cycles inserted before each access, 0..15.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset release; 0 = skip the clear.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_fault  out  1  request rejected; memory unchanged.
- init_done  out  1  clear sequence finished; stays high until next reset.

## Operation
- States: CLEAR, IDLE, ACCESS.
- While rst=0:
  - Every output is 0.
  - Clear counter is 0.
  - Any captured request is discarded.
  - Next state is CLEAR if CLEAR_ON_RESET=1, else IDLE with init_done=1.
- CLEAR:
  - Writes 0 to word[cnt] each cycle, with cnt running 0..DEPTH_WORDS-1.
  - After the last word, the next state is IDLE and init_done goes to 1.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we, funct3, addr and wdata; load wait_cnt=WAIT_STATES; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - If wait_cnt≠0, decrement it.
  - If wait_cnt=0, at the next edge:
    - perform the access;
    - register rsp_rdata and rsp_fault;
    - set rsp_valid=1 for exactly one cycle;
    - go to IDLE.
- Word index = addr[ADDR_W-1:2]. Lane = addr[1:0].
- Fault is raised when any of these holds:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - word index ≥ DEPTH_WORDS;
  - funct3 is 011, 110 or 111;
  - a store with funct3[2]=1.
- On a fault: no write, rsp_rdata=0, rsp_fault=1.
- Stores update only the addressed lanes; other bytes of the word are preserved:
  - sb writes byte lane addr[1:0];
  - sh writes halfword lane addr[1];
  - sw writes the whole word.
- Loads extract the addressed byte or halfword to bits [7:0] or [15:0]:
  - lb/lh sign-extend from bit 7/15;
  - lbu/lhu zero-extend;
  - lw returns the word unchanged.
- A store followed by a load to the same word returns the stored data. Only one request is outstanding, so no bypass logic is needed.

## Timing
- Clear duration: DEPTH_WORDS cycles after the first edge with rst=1. req_ready rises in the cycle after the last clear write.
- Latency: request accepted at edge E0 → rsp_valid high in the cycle following edge E0+1+WAIT_STATES.
- req_ready is high in that same response cycle, so a back-to-back request may be accepted then.
- Peak throughput: one request per WAIT_STATES+2 cycles.
- rsp_rdata and rsp_fault hold their values until the next response. rsp_valid is 0 in every cycle except the response cycle.
- Reset asserted during ACCESS or CLEAR:
  - the access is aborted; no write occurs and no response is produced;
  - after release, the full clear sequence restarts when CLEAR_ON_RESET=1.
- req_valid while req_ready=0 is ignored. The requester holds the request until accepted.

## Test plan
- Reset release, DEPTH_WORDS=16, CLEAR_ON_RESET=1 → req_ready=0 for 16 cycles, then init_done=1. lw at 0x3C returns 0x00000000.
- sw 0x11223344 at 0x8, then sb 0xAA at 0xA → lw at 0x8 returns 0x11AA3344. lb at 0xA returns 0xFFFFFFAA. lbu at 0xA returns 0x000000AA.
- sh 0x8001 at 0x6 over 0 → lh at 0x6 returns 0xFFFF8001, lhu at 0x6 returns 0x00008001, lw at 0x4 returns 0x80010000.
- lw at 0x2, sh at 0x5, and lw at index DEPTH_WORDS → rsp_fault=1 and rsp_rdata=0 for each. A subsequent lw at 0x4 still returns 0x80010000.
- WAIT_STATES=3, request accepted at edge E0 → rsp_valid only in the cycle after E0+4. Back-to-back loads complete every 5 cycles.
- rst=0 for one cycle while a store is in ACCESS → no rsp_valid, target word unchanged (zero after clear), clear restarts.
